spi_dev_fwrite: RTL and testbench

FPGA-side "fwrite" engine: the inverse of the fread path. Fabric logic buffers a payload and submits a write request (file_id, offset, len). The block raises pw_irq. The ESP32 then issues CMD_GET to pull the header plus payload through the SPI protocol wrapper, and later issues CMD_PUT to return a one-byte completion status. It sits beside the other spi_dev_* clients on the protocol-wrapper bus.

---
 rtl/spi_dev_pkg.sv | 15 +
 rtl/fifo_sync_ram.sv | 55 +++++
 rtl/spi_dev_fwrite.sv | 188 ++++++++++++++++++
 tb/tb_spi_dev_fwrite.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dev_pkg.sv
// Shared constants for the spi_dev_* protocol-wrapper clients.
package spi_dev_pkg;

  localparam logic [7:0]  CMD_GET      = 8'hfa;
  localparam logic [7:0]  CMD_PUT      = 8'hfb;
  localparam logic [11:0] HDR_LEN      = 12'd10;
  localparam logic [7:0]  STATUS_ABORT = 8'hFE;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_PEND  = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

endpackage

// File: rtl/fifo_sync_ram.sv
// Single-clock RAM FIFO with registered read data and an occupancy level.
module fifo_sync_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      level_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             push_ok, pop_ok;

  assign full_o    = (level_q == FULL_LVL);
  assign push_ok   = wr_en_i & ~full_o;
  assign pop_ok    = rd_en_i & (level_q != '0);
  assign rd_data_o = rd_data_q;
  assign level_o   = level_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok) begin
        rptr_q    <= rptr_q + 1'b1;
        rd_data_q <= mem[rptr_q];
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_dev_fwrite.sv
// fwrite engine: buffers a payload, raises pw_irq, streams header+payload on GET
// and captures a one-byte completion status on PUT.
module spi_dev_fwrite
  import spi_dev_pkg::*;
#(
  parameter int unsigned BUFFER_DEPTH = 512,
  parameter logic [7:0]  CMD_GET_BYTE = CMD_GET,
  parameter logic [7:0]  CMD_PUT_BYTE = CMD_PUT,
  parameter int unsigned BL           = $clog2(BUFFER_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pw_wdata,
  input  logic        pw_wcmd,
  input  logic        pw_wstb,
  input  logic        pw_end,
  output logic        pw_req,
  input  logic        pw_gnt,
  output logic [7:0]  pw_rdata,
  output logic        pw_rstb,
  output logic        pw_irq,
  input  logic [31:0] req_file_id,
  input  logic [31:0] req_offset,
  input  logic [10:0] req_len,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  dat_data,
  input  logic        dat_valid,
  output logic        dat_ready,
  output logic [7:0]  resp_status,
  output logic        resp_valid
);

  localparam logic [10:0] LEN_MAX = BUFFER_DEPTH[10:0];

  logic        cmd_stb_get_q, cmd_stb_put_q, active_get_q, active_put_q, put_got_q;
  logic [2:0]  state_q, state_d;
  logic [11:0] tx_cnt_q, tx_cnt_d;
  logic [10:0] pop_left_q, pop_left_d;
  logic [7:0]  hdr_q, hdr_d;
  logic        sel_fifo_q, sel_fifo_d;
  logic        rstb_q, rstb_d;
  logic        req_ready_q, req_ready_d;
  logic [7:0]  resp_status_q;
  logic        resp_valid_q;
  logic        fifo_pop, fifo_full, drain_done, put_take;
  logic [7:0]  fifo_rdata;
  logic [BL:0] fifo_level;
  logic [10:0] len_eff;
  logic [11:0] tx_total;

  assign len_eff  = (req_len > LEN_MAX) ? LEN_MAX : req_len;
  assign tx_total = HDR_LEN + {1'b0, len_eff};
  assign put_take = active_put_q & pw_wstb & ~pw_wcmd & ~put_got_q;

  fifo_sync_ram #(
    .DEPTH (BUFFER_DEPTH),
    .WIDTH (8),
    .AW    (BL)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (dat_valid & dat_ready),
    .wr_data_i (dat_data),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .level_o   (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_stb_get_q <= 1'b0;
      cmd_stb_put_q <= 1'b0;
      active_get_q  <= 1'b0;
      active_put_q  <= 1'b0;
      put_got_q     <= 1'b0;
      resp_status_q <= 8'h00;
      resp_valid_q  <= 1'b0;
    end else begin
      cmd_stb_get_q <= pw_wstb & pw_wcmd & (pw_wdata == CMD_GET_BYTE);
      cmd_stb_put_q <= pw_wstb & pw_wcmd & (pw_wdata == CMD_PUT_BYTE);
      active_get_q  <= (active_get_q & ~pw_end) | cmd_stb_get_q;
      active_put_q  <= (active_put_q & ~pw_end) | cmd_stb_put_q;
      put_got_q     <= cmd_stb_put_q ? 1'b0 : (put_got_q | put_take);
      resp_valid_q  <= drain_done | put_take;
      if (drain_done)    resp_status_q <= STATUS_ABORT;
      else if (put_take) resp_status_q <= pw_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_cnt_d    = tx_cnt_q;
    pop_left_d  = pop_left_q;
    hdr_d       = hdr_q;
    sel_fifo_d  = sel_fifo_q;
    rstb_d      = 1'b0;
    req_ready_d = 1'b0;
    fifo_pop    = 1'b0;
    drain_done  = 1'b0;
    case (state_q)
      // req_ready_q guards the retire cycle, when req_valid may still be high
      ST_IDLE: if (req_valid && !req_ready_q) begin
        state_d    = ST_WAIT;
        pop_left_d = len_eff;
      end
      ST_WAIT: if (11'(fifo_level) >= len_eff) state_d = ST_PEND;
      ST_PEND: if (cmd_stb_get_q) state_d = ST_SEND;
      ST_SEND: begin
        if (pw_gnt && tx_cnt_q < tx_total) begin
          rstb_d   = 1'b1;
          tx_cnt_d = tx_cnt_q + 12'd1;
          if (tx_cnt_q < HDR_LEN) begin
            sel_fifo_d = 1'b0;
            case (tx_cnt_q[3:0])
              4'd0:    hdr_d = req_file_id[31:24];
              4'd1:    hdr_d = req_file_id[23:16];
              4'd2:    hdr_d = req_file_id[15:8];
              4'd3:    hdr_d = req_file_id[7:0];
              4'd4:    hdr_d = req_offset[31:24];
              4'd5:    hdr_d = req_offset[23:16];
              4'd6:    hdr_d = req_offset[15:8];
              4'd7:    hdr_d = req_offset[7:0];
              4'd8:    hdr_d = {5'b0, len_eff[10:8]};
              default: hdr_d = len_eff[7:0];
            endcase
          end else begin
            sel_fifo_d = 1'b1;
            fifo_pop   = 1'b1;
            pop_left_d = pop_left_q - 11'd1;
          end
        end
        if (pw_end) begin
          if (tx_cnt_q == tx_total) begin
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop_left_q != '0) begin
          fifo_pop   = 1'b1;
          pop_left_d = pop_left_q - 11'd1;
        end else begin
          drain_done  = 1'b1;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!pw_gnt || state_q != ST_SEND) tx_cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tx_cnt_q    <= '0;
      pop_left_q  <= '0;
      hdr_q       <= '0;
      sel_fifo_q  <= 1'b0;
      rstb_q      <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_cnt_q    <= tx_cnt_d;
      pop_left_q  <= pop_left_d;
      hdr_q       <= hdr_d;
      sel_fifo_q  <= sel_fifo_d;
      rstb_q      <= rstb_d;
      req_ready_q <= req_ready_d;
    end
  end

  // Payload bytes come straight from the FIFO's read register, aligned with rstb_q
  assign pw_rdata    = sel_fifo_q ? fifo_rdata : hdr_q;
  assign pw_rstb     = rstb_q;
  assign pw_req      = active_get_q;
  assign pw_irq      = (state_q == ST_PEND) || (state_q == ST_SEND);
  assign req_ready   = req_ready_q;
  assign dat_ready   = ~fifo_full & ~rst;
  assign resp_status = resp_status_q;
  assign resp_valid  = resp_valid_q;

endmodule

// File: tb/tb_spi_dev_fwrite.sv
// Directed bench for spi_dev_fwrite: wrapper/fabric driven from one process,
// outputs captured on the falling edge.
module tb_spi_dev_fwrite;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pw_wdata = '0;
  logic        pw_wcmd = 1'b0, pw_wstb = 1'b0, pw_end = 1'b0, pw_gnt = 1'b0;
  logic        pw_req, pw_rstb, pw_irq, req_ready, dat_ready, resp_valid;
  logic [7:0]  pw_rdata, resp_status;
  logic [31:0] req_file_id = '0, req_offset = '0;
  logic [10:0] req_len = '0;
  logic        req_valid = 1'b0;
  logic [7:0]  dat_data = '0;
  logic        dat_valid = 1'b0;

  int unsigned checks = 0, failures = 0;
  logic [7:0]  got [2048];
  int unsigned ncap = 0, rv_cnt = 0, rr_cnt = 0, both_cnt = 0;
  bit          cap_en = 1'b0;
  logic [7:0]  exp_q [$];

  spi_dev_fwrite #(.BUFFER_DEPTH(512)) dut (
    .clk(clk), .rst(rst), .pw_wdata(pw_wdata), .pw_wcmd(pw_wcmd), .pw_wstb(pw_wstb),
    .pw_end(pw_end), .pw_req(pw_req), .pw_gnt(pw_gnt), .pw_rdata(pw_rdata),
    .pw_rstb(pw_rstb), .pw_irq(pw_irq), .req_file_id(req_file_id),
    .req_offset(req_offset), .req_len(req_len), .req_valid(req_valid),
    .req_ready(req_ready), .dat_data(dat_data), .dat_valid(dat_valid),
    .dat_ready(dat_ready), .resp_status(resp_status), .resp_valid(resp_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cap_en && pw_rstb && ncap < 2048) begin
      got[ncap] = pw_rdata;
      ncap++;
    end
    if (resp_valid) rv_cnt++;
    if (req_ready) rr_cnt++;
    if (resp_valid && req_ready) both_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic c);
    pw_wdata = d; pw_wcmd = c; pw_wstb = 1'b1;
    tick();
    pw_wstb = 1'b0; pw_wcmd = 1'b0;
    tick(2);
  endtask

  task automatic push(input logic [7:0] d);
    dat_data = d; dat_valid = 1'b1;
    tick();
    dat_valid = 1'b0;
  endtask

  task automatic request(input logic [31:0] id, input logic [31:0] off, input logic [10:0] len);
    req_file_id = id; req_offset = off; req_len = len; req_valid = 1'b1;
    tick();
  endtask

  task automatic wait_irq(input string tag);
    for (int i = 0; i < 20 && !pw_irq; i++) tick();
    check(tag, pw_irq, 1);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 10 && !pw_req; i++) tick();
    check("get_req", pw_req, 1);
  endtask

  task automatic do_get(input int unsigned end_after, input bit full);
    int unsigned b, r0;
    b = ncap; r0 = rr_cnt;
    cap_en = 1'b1;
    wr_byte(8'hfa, 1'b1);
    wait_req();
    pw_gnt = 1'b1;
    for (int i = 0; i < 800 && (ncap - b) < end_after; i++) tick();
    if (full) tick(4);
    pw_end = 1'b1;
    tick();
    pw_end = 1'b0;
    for (int i = 0; i < 40 && rr_cnt == r0; i++) tick();
    req_valid = 1'b0;
    pw_gnt = 1'b0;
    tick(2);
    cap_en = 1'b0;
  endtask

  task automatic cmp_stream(input string tag, input int unsigned b);
    int unsigned n, errs;
    n = ncap - b; errs = 0;
    check({tag, "_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < int'(n); i++)
      if (got[b + i] !== exp_q[i]) errs++;
    check({tag, "_bytes"}, errs, 0);
  endtask

  initial begin
    int unsigned b, rr0, rv0, bo0, errs;

    #1 rst = 1'b1;
    #2;
    check("rst_pw_req", pw_req, 0);
    check("rst_pw_rdata", pw_rdata, 0);
    check("rst_pw_rstb", pw_rstb, 0);
    check("rst_pw_irq", pw_irq, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_dat_ready", dat_ready, 0);
    check("rst_resp_status", resp_status, 0);
    check("rst_resp_valid", resp_valid, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    check("post_rst_dat_ready", dat_ready, 1);

    // T1: len=4 full GET
    request(32'h01020304, 32'h00001000, 11'd4);
    tick(3);
    check("t1_irq_early", pw_irq, 0);
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    wait_irq("t1_irq");
    rr0 = rr_cnt; b = ncap;
    do_get(14, 1'b1);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h04,
              8'hA0, 8'hA1, 8'hA2, 8'hA3};
    cmp_stream("t1", b);
    check("t1_ready", rr_cnt - rr0, 1);
    check("t1_irq_off", pw_irq, 0);

    // T2: len=0, header only
    request(32'h00000001, 32'h00000002, 11'd0);
    wait_irq("t2_irq");
    rr0 = rr_cnt; b = ncap;
    do_get(10, 1'b1);
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00};
    cmp_stream("t2", b);
    check("t2_ready", rr_cnt - rr0, 1);

    // T3: short GET, len=8 ended after 6 bytes
    request(32'h11111111, 32'h0, 11'd8);
    for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
    wait_irq("t3_irq");
    rr0 = rr_cnt; rv0 = rv_cnt; bo0 = both_cnt;
    do_get(6, 1'b0);
    check("t3_ready", rr_cnt - rr0, 1);
    check("t3_resp_valid", rv_cnt - rv0, 1);
    check("t3_both", both_cnt - bo0, 1);
    check("t3_status", resp_status, 8'hFE);
    check("t3_irq_off", pw_irq, 0);

    // T4: PUT 00 then 55
    rv0 = rv_cnt;
    wr_byte(8'hfb, 1'b1);
    wr_byte(8'h00, 1'b0);
    wr_byte(8'h55, 1'b0);
    pw_end = 1'b1; tick(); pw_end = 1'b0; tick(3);
    check("t4_resp_valid", rv_cnt - rv0, 1);
    check("t4_status", resp_status, 8'h00);

    // T5: fill FIFO, 513th byte dropped, len=512 GET
    errs = 0;
    for (int i = 0; i < 512; i++) begin
      if (!dat_ready) errs++;
      push(8'(i));
    end
    check("t5_ready_before_full", errs, 0);
    dat_data = 8'hEE; dat_valid = 1'b1;
    check("t5_full_ready", dat_ready, 0);
    tick();
    dat_valid = 1'b0;
    request(32'hDEADBEEF, 32'h00000200, 11'd512);
    wait_irq("t5_irq");
    rr0 = rr_cnt; b = ncap;
    do_get(522, 1'b1);
    exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00};
    for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
    cmp_stream("t5", b);
    check("t5_ready", rr_cnt - rr0, 1);

    // T6: len=1 shows the dropped byte never entered the FIFO
    request(32'h000000AA, 32'h0, 11'd1);
    push(8'h5A);
    wait_irq("t6_irq");
    b = ncap;
    do_get(11, 1'b1);
    exp_q = '{8'h00, 8'h00, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h5A};
    cmp_stream("t6", b);

    // second PUT re-arms the capture
    rv0 = rv_cnt;
    wr_byte(8'hfb, 1'b1);
    wr_byte(8'h3C, 1'b0);
    pw_end = 1'b1; tick(); pw_end = 1'b0; tick(3);
    check("put2_resp_valid", rv_cnt - rv0, 1);
    check("put2_status", resp_status, 8'h3C);

    // T7: async reset mid-SEND
    request(32'h0A0B0C0D, 32'h0, 11'd8);
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    wait_irq("t7_irq");
    rr0 = rr_cnt; b = ncap;
    cap_en = 1'b1;
    wr_byte(8'hfa, 1'b1);
    wait_req();
    pw_gnt = 1'b1;
    for (int i = 0; i < 40 && (ncap - b) < 3; i++) tick();
    check("t7_midsend_irq", pw_irq, 1);
    #2 rst = 1'b1;
    #1;
    check("t7_rst_irq", pw_irq, 0);
    check("t7_rst_req", pw_req, 0);
    check("t7_rst_rstb", pw_rstb, 0);
    check("t7_rst_rdata", pw_rdata, 0);
    check("t7_rst_ready", req_ready, 0);
    check("t7_rst_dat_ready", dat_ready, 0);
    check("t7_rst_status", resp_status, 0);
    pw_gnt = 1'b0; req_valid = 1'b0; cap_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(3);
    check("t7_no_ready", rr_cnt - rr0, 0);
    check("t7_irq_after", pw_irq, 0);

    // T8: FIFO was flushed, next request normal
    request(32'h11223344, 32'h55667788, 11'd2);
    push(8'hC1);
    push(8'hC2);
    wait_irq("t8_irq");
    rr0 = rr_cnt; b = ncap;
    do_get(12, 1'b1);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 8'h02,
              8'hC1, 8'hC2};
    cmp_stream("t8", b);
    check("t8_ready", rr_cnt - rr0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
